// File: rtl/elastic_delay_pipe.sv
`default_nettype none
// ============================================================================
// Module   : elastic_delay_pipe
// Brief    : DEPTH-stage valid/ready register pipeline with bubble collapse,
//            synchronous flush and a registered occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module elastic_delay_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_dat [DEPTH];
  logic [OCC_W-1:0] r_occ;

  logic [DEPTH:0]   w_rdy;
  logic [DEPTH-1:0] w_pred_vld;
  logic [WIDTH-1:0] w_pred_dat [DEPTH];
  logic             w_accept;
  logic             w_deliver;

  // A stage can load whenever any stage at or beyond it is empty, or the
  // sink is draining; this is what lets bubbles collapse under backpressure.
  always_comb begin
    w_rdy        = '0;
    w_rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_rdy[i] = !r_vld[i] || w_rdy[i+1];
    end
  end

  assign in_ready  = w_rdy[0] && !flush;
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = r_vld[DEPTH-1] && out_ready;

  always_comb begin
    w_pred_vld    = '0;
    w_pred_vld[0] = w_accept;
    w_pred_dat[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_pred_vld[i] = r_vld[i-1];
      w_pred_dat[i] = r_dat[i-1];
    end
  end

  // Data only loads under a valid predecessor, so idle or X input never
  // disturbs the stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_dat[i] <= RESET_VAL;
      end
    end else if (flush) begin
      r_vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_vld[i] <= w_pred_vld[i];
          if (w_pred_vld[i]) begin
            r_dat[i] <= w_pred_dat[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_accept && !w_deliver) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (!w_accept && w_deliver) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign out_valid = r_vld[DEPTH-1];
  assign out_data  = r_dat[DEPTH-1];
  assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_elastic_delay_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_elastic_delay_pipe
// Brief    : Three pipe depths on shared stimulus, checked against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elastic_delay_pipe;

  localparam int         NI       = 3;
  localparam int         DEP [NI] = '{2, 4, 3};
  localparam logic [7:0] RV  [NI] = '{8'hA5, 8'hA5, 8'h3C};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic [NI-1:0] s_rdy, s_vld;
  logic [7:0] s_dat [NI];
  logic [1:0] s_occ0;
  logic [2:0] s_occ1;
  logic [1:0] s_occ2;

  elastic_delay_pipe #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'hA5)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(s_rdy[0]), .in_data(in_data), .out_valid(s_vld[0]),
    .out_ready(out_ready), .out_data(s_dat[0]), .occupancy(s_occ0));

  elastic_delay_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_d4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(s_rdy[1]), .in_data(in_data), .out_valid(s_vld[1]),
    .out_ready(out_ready), .out_data(s_dat[1]), .occupancy(s_occ1));

  elastic_delay_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h3C)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(s_rdy[2]), .in_data(in_data), .out_valid(s_vld[2]),
    .out_ready(out_ready), .out_data(s_dat[2]), .occupancy(s_occ2));

  // Model: per pipe, the beats in flight oldest-first with their stage index.
  int         m_cnt  [NI];
  int         m_pos  [NI][8];
  logic [7:0] m_dat  [NI][8];
  logic [7:0] m_last [NI];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int occ_of(input int n);
    case (n)
      0:       return int'(s_occ0);
      1:       return int'(s_occ1);
      default: return int'(s_occ2);
    endcase
  endfunction

  function automatic bit model_ready(input int n);
    return (m_cnt[n] < DEP[n] || out_ready) && !flush;
  endfunction

  task automatic model_clear(input int n);
    m_cnt[n]  = 0;
    m_last[n] = RV[n];
  endtask

  // A beat advances when the sink drains or some stage ahead of it is empty;
  // ahead of beat j sit exactly j older beats.
  task automatic model_step(input int n);
    int         d;
    int         k;
    int         p;
    bit         acc;
    int         np [8];
    logic [7:0] nd [8];
    d   = DEP[n];
    k   = 0;
    acc = in_valid && model_ready(n);
    if (flush) begin
      m_cnt[n] = 0;
      return;
    end
    for (int j = 0; j < m_cnt[n]; j++) begin
      p = m_pos[n][j];
      if (p == d - 1) begin
        if (!out_ready) begin
          np[k] = p; nd[k] = m_dat[n][j]; k++;
        end
      end else begin
        if (out_ready || j < d - 1 - p) p++;
        if (p == d - 1) m_last[n] = m_dat[n][j];
        np[k] = p; nd[k] = m_dat[n][j]; k++;
      end
    end
    if (acc) begin
      np[k] = 0; nd[k] = in_data;
      if (d == 1) m_last[n] = in_data;
      k++;
    end
    m_cnt[n] = k;
    for (int j = 0; j < k; j++) begin
      m_pos[n][j] = np[j];
      m_dat[n][j] = nd[j];
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int n = 0; n < NI; n++) begin
        if (!rst_n) model_clear(n);
        chk($sformatf("u%0d in_ready", n), 32'(s_rdy[n]), 32'(model_ready(n)));
        chk($sformatf("u%0d out_valid", n), 32'(s_vld[n]),
            32'(m_cnt[n] > 0 && m_pos[n][0] == DEP[n] - 1));
        chk($sformatf("u%0d out_data", n), 32'(s_dat[n]), 32'(m_last[n]));
        chk($sformatf("u%0d occupancy", n), occ_of(n), m_cnt[n]);
      end
      @(posedge clk);
      for (int n = 0; n < NI; n++) begin
        if (!rst_n) model_clear(n);
        else        model_step(n);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 'x;
    repeat (3) cyc();
    chk("reset out_valid", 32'(s_vld[0]), 32'd0);
    chk("reset out_data", 32'(s_dat[0]), 32'hA5);
    chk("reset occupancy", occ_of(0), 0);
    rst_n = 1'b1;
    #1 chk("in_ready after release", 32'(s_rdy[0]), 32'd1);

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1);
      cyc();
      if (i == 1) chk("d2 latency out_data", 32'(s_dat[0]), 32'h01);
      if (i == 2) chk("d4 not yet valid", 32'(s_vld[1]), 32'd0);
      if (i == 3) begin
        chk("d4 latency out_valid", 32'(s_vld[1]), 32'd1);
        chk("d4 latency out_data", 32'(s_dat[1]), 32'h01);
      end
      if (i == 5) chk("d4 stream occupancy", occ_of(1), 4);
    end
    in_valid = 1'b0; in_data = 'x;
    repeat (6) cyc();

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      cyc();
    end
    in_data = 8'h14;
    #1 chk("d4 full in_ready", 32'(s_rdy[1]), 32'd0);
    chk("d4 full occupancy", occ_of(1), 4);
    cyc();
    out_ready = 1'b1;
    #1 chk("d4 full+pop in_ready", 32'(s_rdy[1]), 32'd1);
    chk("d4 drain 0", 32'(s_dat[1]), 32'h10);
    cyc();
    in_valid = 1'b0; in_data = 'x;
    for (int j = 1; j <= 4; j++) begin
      #1 chk($sformatf("d4 drain %0d", j), 32'({s_vld[1], s_dat[1]}), 32'({1'b1, 8'(8'h10 + j)}));
      cyc();
    end
    chk("d4 empty after drain", occ_of(1), 0);

    repeat (4) cyc();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h20; cyc();
    in_valid = 1'b0; in_data = 'x;    cyc();
    in_valid = 1'b1; in_data = 8'h21; cyc();
    in_valid = 1'b0; in_data = 'x;
    repeat (2) cyc();
    chk("collapse occupancy", occ_of(1), 2);
    chk("collapse head", 32'({s_vld[1], s_dat[1]}), 32'({1'b1, 8'h20}));
    out_ready = 1'b1;
    cyc();
    chk("collapse second at stage 2", 32'({s_vld[1], s_dat[1]}), 32'({1'b1, 8'h21}));

    repeat (4) cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h30 + i);
      cyc();
    end
    in_data = 8'h33; out_ready = 1'b1;
    #1 chk("d3 full+pop in_ready", 32'(s_rdy[2]), 32'd1);
    chk("d3 full occupancy", occ_of(2), 3);
    cyc();
    chk("d3 simultaneous occupancy", occ_of(2), 3);
    chk("d3 simultaneous out_data", 32'(s_dat[2]), 32'h31);
    in_data = 8'h34;
    cyc();
    chk("d3 simultaneous out_data 2", 32'(s_dat[2]), 32'h32);

    in_data = 8'h35; out_ready = 1'b0; flush = 1'b1;
    #1 chk("flush in_ready", 32'(s_rdy[2]), 32'd0);
    cyc();
    flush = 1'b0; in_valid = 1'b0; in_data = 'x;
    chk("flush occupancy", occ_of(2), 0);
    chk("flush out_valid", 32'(s_vld[2]), 32'd0);
    chk("flush data holds", 32'(s_dat[2]), 32'h32);

    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = in_valid ? 8'($urandom) : 'x;
      if (((i / 50) % 2) == 1) out_ready = ($urandom_range(0, 3) == 0);
      else                     out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      cyc();
    end
    flush = 1'b0;

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i);
      cyc();
    end
    in_valid = 1'b0; in_data = 'x;
    #1 chk("pre-reset out_valid", 32'(s_vld[1]), 32'd1);
    rst_n = 1'b0;
    #1 chk("async reset out_valid", 32'(s_vld[1]), 32'd0);
    chk("async reset out_data", 32'(s_dat[1]), 32'hA5);
    chk("async reset occupancy", occ_of(1), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
